// File: rtl/pulse_rx.sv
// pulse_rx: receives LSB-first words from a pulse-burst line (burst in a bit period = 1).
// Defining PULSE_RX_STATS_EN adds the saturating word_count / glitch_count outputs.
module pulse_rx #(
  parameter int BIT_PERIOD = 108,
  parameter int MIN_PULSE  = 24,
  parameter int WORD_BITS  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  output logic [WORD_BITS-1:0] word_data,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 busy,
  output logic                 overrun
`ifdef PULSE_RX_STATS_EN
  ,
  output logic [15:0]          word_count,
  output logic [15:0]          glitch_count
`endif
);

  localparam int PH_W  = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int CNT_W = $clog2(BIT_PERIOD + 1);
  localparam int IDX_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BIT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_PULSE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BITS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  logic                 sync_meta_r;
  logic                 s_in_r;
  logic                 s_in_d_r;
  state_t               state_r;
  state_t               state_s;
  logic [PH_W-1:0]      phase_r;
  logic [PH_W-1:0]      phase_s;
  logic [IDX_W-1:0]     bit_idx_r;
  logic [IDX_W-1:0]     bit_idx_s;
  logic [CNT_W-1:0]     high_cnt_r;
  logic [CNT_W-1:0]     high_cnt_s;
  logic [CNT_W-1:0]     cnt_now_s;
  logic [WORD_BITS-1:0] shift_r;
  logic [WORD_BITS-1:0] shift_s;
  logic                 bit_s;
  logic                 rise_s;
  logic                 word_done_s;
  logic                 glitch_s;
  logic                 load_s;
  logic                 drop_s;
  logic [WORD_BITS-1:0] word_data_r;
  logic                 word_valid_r;
  logic                 busy_r;
  logic                 overrun_r;

  assign rise_s = s_in_r & ~s_in_d_r;

  // Two-flop synchronizer plus one-cycle delay for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta_r <= 1'b0;
      s_in_r      <= 1'b0;
      s_in_d_r    <= 1'b0;
    end else begin
      sync_meta_r <= in;
      s_in_r      <= sync_meta_r;
      s_in_d_r    <= s_in_r;
    end
  end

  // FSM and bit-timing state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      phase_r    <= '0;
      bit_idx_r  <= '0;
      high_cnt_r <= '0;
      shift_r    <= '0;
    end else begin
      state_r    <= state_s;
      phase_r    <= phase_s;
      bit_idx_r  <= bit_idx_s;
      high_cnt_r <= high_cnt_s;
      shift_r    <= shift_s;
    end
  end

  // Next-state logic: sample counting, bit resolution, glitch and completion detection.
  always_comb begin
    state_s     = state_r;
    phase_s     = phase_r;
    bit_idx_s   = bit_idx_r;
    high_cnt_s  = high_cnt_r;
    shift_s     = shift_r;
    bit_s       = 1'b0;
    word_done_s = 1'b0;
    glitch_s    = 1'b0;
    cnt_now_s   = (s_in_r && (high_cnt_r != CNT_MAX)) ? (high_cnt_r + CNT_W'(1)) : high_cnt_r;
    case (state_r)
      IDLE: begin
        // The detecting cycle is itself the first high sample of bit 0.
        if (rise_s) begin
          state_s    = RECV;
          phase_s    = '0;
          bit_idx_s  = '0;
          high_cnt_s = CNT_W'(1);
          shift_s    = '0;
        end else begin
          state_s = IDLE;
        end
      end
      RECV: begin
        if (phase_r == PH_LAST) begin
          bit_s              = (cnt_now_s >= CNT_MIN);
          shift_s[bit_idx_r] = bit_s;
          phase_s            = '0;
          high_cnt_s         = '0;
          bit_idx_s          = bit_idx_r + IDX_W'(1);
          if ((bit_idx_r == '0) && !bit_s) begin
            glitch_s = 1'b1;
          end else if (bit_idx_r == IDX_LAST) begin
            word_done_s = 1'b1;
          end else begin
            glitch_s = 1'b0;
          end
        end else begin
          phase_s    = phase_r + PH_W'(1);
          high_cnt_s = cnt_now_s;
        end
        if (glitch_s || word_done_s) begin
          state_s = IDLE;
        end else begin
          state_s = RECV;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign load_s = word_done_s & (~word_valid_r | word_ready);
  assign drop_s = word_done_s & word_valid_r & ~word_ready;

  // Output word buffer, handshake, busy and sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_data_r  <= '0;
      word_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      busy_r <= (state_s == RECV);
      if (load_s) begin
        word_data_r  <= shift_s;
        word_valid_r <= 1'b1;
      end else if (word_valid_r && word_ready) begin
        word_valid_r <= 1'b0;
      end else begin
        word_valid_r <= word_valid_r;
      end
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign word_data  = word_data_r;
  assign word_valid = word_valid_r;
  assign busy       = busy_r;
  assign overrun    = overrun_r;

`ifdef PULSE_RX_STATS_EN
  logic [15:0] word_count_r;
  logic [15:0] glitch_count_r;

  // Saturating counters of delivered words and rejected glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count_r   <= 16'h0000;
      glitch_count_r <= 16'h0000;
    end else begin
      if (load_s && (word_count_r != 16'hFFFF)) begin
        word_count_r <= word_count_r + 16'h0001;
      end else begin
        word_count_r <= word_count_r;
      end
      if (glitch_s && (glitch_count_r != 16'hFFFF)) begin
        glitch_count_r <= glitch_count_r + 16'h0001;
      end else begin
        glitch_count_r <= glitch_count_r;
      end
    end
  end

  assign word_count   = word_count_r;
  assign glitch_count = glitch_count_r;
`endif

endmodule

// File: tb/tb_pulse_rx.sv
// Scoreboard bench for pulse_rx: directed bursts push expected words, a monitor pops on each new word.
module tb_pulse_rx;

  localparam int BP  = 108;
  localparam int MP  = 24;
  localparam int WB  = 8;
  localparam int LAT = 2 + WB * BP;

  logic          clk = 1'b0;
  logic          reset;
  logic          line_in;
  logic          word_ready;
  logic [WB-1:0] word_data;
  logic          word_valid;
  logic          busy;
  logic          overrun;
`ifdef PULSE_RX_STATS_EN
  logic [15:0]   word_count;
  logic [15:0]   glitch_count;
`endif

  pulse_rx #(.BIT_PERIOD(BP), .MIN_PULSE(MP), .WORD_BITS(WB)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (line_in),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .overrun    (overrun)
`ifdef PULSE_RX_STATS_EN
    ,
    .word_count   (word_count),
    .glitch_count (glitch_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [WB-1:0] data;
    int            at;
  } exp_t;

  exp_t          exp_q[$];
  int            burst_len[WB];
  logic          prev_valid = 1'b0;
  logic [WB-1:0] prev_data  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit 0 window spans sends t=0..BP; bit k>0 spans t=k*BP+1..(k+1)*BP.
  function automatic logic burst_bit(input int t);
    int k;
    int pos;
    if (t <= BP) begin
      k   = 0;
      pos = t;
    end else begin
      k   = (t - 1) / BP;
      pos = (t - 1) % BP;
    end
    if (k >= WB) return 1'b0;
    return (pos < burst_len[k]);
  endfunction

  task automatic set_bursts(input logic [WB-1:0] w, input int len);
    for (int k = 0; k < WB; k++) burst_len[k] = w[k] ? len : 0;
  endtask

  task automatic send(input logic [WB-1:0] w, input bit push, input int stop_t, input bit accept_end);
    exp_t e;
    for (int t = 0; t < stop_t; t++) begin
      @(negedge clk);
      if (t == 0 && push) begin
        e.data = w;
        e.at   = cyc + LAT + 1;
        exp_q.push_back(e);
      end
      line_in = burst_bit(t);
      if (accept_end) word_ready = (t == LAT);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      line_in = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    line_in = 1'b0;
    #1;
    check("rst_word_data", 32'(word_data), 32'h0);
    check("rst_word_valid", 32'(word_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
`ifdef PULSE_RX_STATS_EN
    check("rst_word_count", 32'(word_count), 32'h0);
    check("rst_glitch_count", 32'(glitch_count), 32'h0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: a new word is presented when valid is high and the previous one was not held.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !word_ready && word_valid) begin
        checks++;
        if (word_data !== prev_data) begin
          failures++;
          $display("FAIL hold_stable: got %0h expected %0h", word_data, prev_data);
        end
      end
      if (word_valid && !(prev_valid && !word_ready)) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: got %0h at cycle %0d expected none", word_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (word_data !== e.data || cyc != e.at) begin
            failures++;
            $display("FAIL word: got %0h at cycle %0d expected %0h at cycle %0d",
                     word_data, cyc, e.data, e.at);
          end
        end
      end
      prev_valid = word_valid;
      prev_data  = word_data;
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    line_in    = 1'b0;
    word_ready = 1'b0;
    #2;
    do_reset();
    idle(3);

    // 0xA5 with 49-cycle bursts, consumer always ready: one-cycle valid pulse.
    word_ready = 1'b1;
    set_bursts(8'hA5, 49);
    send(8'hA5, 1'b1, LAT + 1, 1'b0);
    @(negedge clk);
    check("a5_valid", 32'(word_valid), 32'h1);
    check("a5_data", 32'(word_data), 32'hA5);
    @(negedge clk);
    check("a5_valid_pulse", 32'(word_valid), 32'h0);
    idle(5);

    // Threshold: 24-sample bursts are ones, a 23-sample burst is a zero.
    set_bursts(8'h0B, 24);
    burst_len[2] = 23;
    send(8'h0B, 1'b1, LAT + 1, 1'b0);
    @(negedge clk);
    check("thr_data", 32'(word_data), 32'h0B);
    idle(5);

    // Lone 10-cycle pulse is a glitch; busy lasts 108 clocks.
    set_bursts(8'h01, 10);
    send(8'h00, 1'b0, BP + 1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("glitch_busy_hi", 32'(busy), 32'h1);
    @(negedge clk);
    check("glitch_busy_lo", 32'(busy), 32'h0);
    check("glitch_no_valid", 32'(word_valid), 32'h0);
`ifdef PULSE_RX_STATS_EN
    check("glitch_count", 32'(glitch_count), 32'h1);
`endif
    idle(20);

    // Overrun: second word dropped while the first is unconsumed.
    do_reset();
    word_ready = 1'b0;
    idle(3);
    set_bursts(8'h01, 49);
    send(8'h01, 1'b1, LAT + 1, 1'b0);
    idle(5);
    set_bursts(8'h03, 49);
    send(8'h03, 1'b0, LAT + 1, 1'b0);
    @(negedge clk);
    check("ovr_data", 32'(word_data), 32'h01);
    check("ovr_valid", 32'(word_valid), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);
`ifdef PULSE_RX_STATS_EN
    check("ovr_word_count", 32'(word_count), 32'h1);
`endif
    @(negedge clk);
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    check("ovr_consumed", 32'(word_valid), 32'h0);

    // Reset in the middle of 0xFF, then a clean 0x81.
    idle(3);
    set_bursts(8'hFF, 49);
    send(8'hFF, 1'b0, 4 * BP + 20, 1'b0);
    do_reset();
    idle(3);
    set_bursts(8'h81, 49);
    send(8'h81, 1'b1, LAT + 1, 1'b0);
    @(negedge clk);
    check("rst_then_data", 32'(word_data), 32'h81);
    check("rst_then_valid", 32'(word_valid), 32'h1);
    check("rst_then_overrun", 32'(overrun), 32'h0);
    idle(5);

    // Completion in the same cycle the held 0x81 is accepted: no valid gap.
    set_bursts(8'h5B, 49);
    send(8'h5B, 1'b1, LAT + 1, 1'b1);
    @(negedge clk);
    word_ready = 1'b0;
    check("b2b_valid", 32'(word_valid), 32'h1);
    check("b2b_data", 32'(word_data), 32'h5B);
    check("b2b_overrun", 32'(overrun), 32'h0);
`ifdef PULSE_RX_STATS_EN
    check("b2b_word_count", 32'(word_count), 32'h2);
`endif
    @(negedge clk);
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    check("b2b_consumed", 32'(word_valid), 32'h0);
    idle(5);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_rx.md
PULSE_RX -- requirements
Module: pulse_rx

Interface
- REQ-001: Parameter BIT_PERIOD, default 108: clocks per bit period.
- REQ-002: Parameter MIN_PULSE, default 24: minimum high samples within a period for the bit to be 1.
- REQ-003: Parameter WORD_BITS, default 32: bits per received word.
- REQ-004: clk  input  1  sole clock; all logic on its rising edge.
- REQ-005: reset  input  1  asynchronous, active-high reset.
- REQ-006: in  input  1  asynchronous pulse-burst line; a 1 bit is a high burst within a bit period, a 0 bit is no burst.
- REQ-007: word_data  output  WORD_BITS  received word, LSB first: bit k of the word is word_data[k].
- REQ-008: word_valid  output  1  word_data holds an unconsumed word.
- REQ-009: word_ready  input  1  consumer accepts word_data when high with word_valid.
- REQ-010: busy  output  1  high while in state RECV.
- REQ-011: overrun  output  1  sticky flag: a completed word was dropped.

Function
- REQ-012: in SHALL pass through a 2-flop synchronizer; all logic below uses the synchronized signal s_in; s_in_d is s_in delayed one cycle.
- REQ-013: The FSM SHALL have two states, IDLE and RECV.
- REQ-014: In IDLE, a rising edge (s_in=1, s_in_d=0) SHALL enter RECV with phase=0, bit_idx=0, high_cnt=1; that cycle counts as the first sample of bit 0.
- REQ-015: In RECV, phase SHALL increment each cycle and wrap from BIT_PERIOD-1 to 0; high_cnt SHALL count the s_in=1 samples of the current period, saturating at BIT_PERIOD.
- REQ-016: At phase=BIT_PERIOD-1, the bit SHALL resolve to (high_cnt including this sample >= MIN_PULSE), shift into the assembly register at index bit_idx, and bit_idx SHALL increment.
- REQ-017: If bit 0 resolves to 0, the block SHALL declare a glitch, discard the word and return to IDLE without asserting word_valid.
- REQ-018: When bit WORD_BITS-1 resolves, the FSM SHALL return to IDLE and the word is complete; a rising edge in that same cycle SHALL be ignored.
- REQ-019: On word completion with word_valid=0, or with word_valid=1 and word_ready=1 in that cycle, word_data SHALL load the new word and word_valid SHALL be 1 on the next cycle.
- REQ-020: On word completion with word_valid=1 and word_ready=0, the new word SHALL be discarded, word_data SHALL be held, and overrun SHALL set.
- REQ-021: word_valid SHALL clear on the cycle after word_valid and word_ready are both high, unless REQ-019 reloads it in that cycle.
- REQ-022: Latency: word_valid SHALL rise exactly 2+WORD_BITS*BIT_PERIOD clocks after the clk edge that first samples in=1.
- REQ-023: word_data SHALL be stable while word_valid=1 and word_ready=0.

Reset
- REQ-024: reset SHALL immediately clear the FSM to IDLE, the synchronizer, phase, bit_idx, high_cnt, the assembly register, word_data, word_valid, busy, overrun and the stats counters, regardless of any operation in progress.
- REQ-025: After reset deasserts, the first rising edge on s_in SHALL start a fresh word; no partial word from before reset SHALL survive.

Configuration
- REQ-026: Macro PULSE_RX_STATS_EN.
- REQ-027: With PULSE_RX_STATS_EN defined, the block SHALL add two outputs: word_count [15:0], which counts words loaded per REQ-019, and glitch_count [15:0], which counts glitches per REQ-017. Both SHALL saturate at 16'hFFFF and clear on reset.
- REQ-028: Without PULSE_RX_STATS_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification (bench uses BIT_PERIOD=108, MIN_PULSE=24, WORD_BITS=8)
- REQ-029: Send word 0xA5 as 49-cycle bursts per period, with word_ready=1 -> word_valid pulses 1 cycle with word_data=0xA5, exactly 866 clocks after the first high sample.
- REQ-030: Send bit-1 bursts of 24 and 23 cycles (pattern 1,1,0(23-cycle burst),1,0,0,0,0) -> word_data=0x0B.
- REQ-031: Send a 10-cycle lone pulse -> no word_valid, busy drops after 108 clocks, glitch_count=1 (stats build).
- REQ-032: Send 0x01 then 0x03 with word_ready=0 throughout -> word_data=0x01 held, overrun=1, word_count=1; then raise word_ready for 1 cycle -> word_valid=0.
- REQ-033: Assert reset at bit 4 of word 0xFF, then send 0x81 -> all outputs 0 during reset, then word_data=0x81 with word_valid=1 and overrun=0.
- REQ-034: Word completes in the same cycle word_ready accepts the previous word -> the new word loads and word_valid stays 1 with no gap.
